// File: rtl/gray_front_pkg.sv
// gray_front_pkg: shared constants and types for the gray_front luma feeder.
// GRAY_DLY is this stage's fixed latency; downstream RGB delay = SOBEL_DLY + GRAY_DLY.
package gray_front_pkg;

   localparam int GRAY_DLY     = 3;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;
   localparam int COEF_R_DEF   = 77;
   localparam int COEF_G_DEF   = 150;
   localparam int COEF_B_DEF   = 29;

   localparam int PIX_W        = 24;
   localparam int GRAY_W       = 8;
   localparam int X_W          = 10;
   localparam int Y_W          = 9;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } fsm_state_e;

   // Per-pixel tag that travels beside the luma datapath
   typedef struct packed {
      logic [PIX_W-1:0] rgb;
      logic [X_W-1:0]   x;
      logic [Y_W-1:0]   y;
      logic             border;
      logic             eof;
      logic             err;
   } side_t;

endpackage

// File: rtl/gray_luma_pipe.sv
// gray_luma_pipe: three-stage luma datapath (weighted products, sum, round/saturate).
module gray_luma_pipe
   import gray_front_pkg::*;
#(
   parameter int COEF_R = COEF_R_DEF,
   parameter int COEF_G = COEF_G_DEF,
   parameter int COEF_B = COEF_B_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vld_i,
   input  logic [PIX_W-1:0]  rgb_i,
   output logic              vld_o,
   output logic [GRAY_W-1:0] gray_o
);

   logic        vld_p0, vld_p1;
   logic [15:0] pr_p0, pg_p0, pb_p0;
   logic [17:0] sum_p1;

   // Round half up, then clamp to 8 bits
   function automatic logic [GRAY_W-1:0] round_sat(input logic [17:0] s);
      logic [17:0] r;
      r = s + 18'd128;
      if (r[17:8] > 10'd255) return 8'hFF;
      return r[15:8];
   endfunction

   // Valid pipeline and registered luma output (held while no pixel)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_o  <= 1'b0;
         gray_o <= '0;
      end else begin
         vld_p0 <= vld_i;
         vld_p1 <= vld_p0;
         vld_o  <= vld_p1;
         if (vld_p1) gray_o <= round_sat(sum_p1);
      end
   end

   // Datapath stages p0 (products) and p1 (sum); no reset, qualified by valid
   always_ff @(posedge clk) begin
      pr_p0  <= 16'(rgb_i[23:16]) * 16'(COEF_R);
      pg_p0  <= 16'(rgb_i[15:8])  * 16'(COEF_G);
      pb_p0  <= 16'(rgb_i[7:0])   * 16'(COEF_B);
      sum_p1 <= 18'(pr_p0) + 18'(pg_p0) + 18'(pb_p0);
   end

endmodule

// File: rtl/gray_front.sv
// gray_front: camera RGB888 -> 8-bit luma with framing FSM, coordinates and sideband.
// Optional macro GRAY_MINMAX_EN adds per-frame gray_min / gray_max outputs.
module gray_front
   import gray_front_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int COEF_R   = COEF_R_DEF,
   parameter int COEF_G   = COEF_G_DEF,
   parameter int COEF_B   = COEF_B_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pix_valid_in,
   input  logic              sof_in,
   input  logic [PIX_W-1:0]  rgb_in,
   output logic              pix_valid_out,
   output logic [GRAY_W-1:0] rgb_gray,
   output logic [PIX_W-1:0]  rgb_out,
   output logic [X_W-1:0]    x_out,
   output logic [Y_W-1:0]    y_out,
   output logic              border_out,
   output logic              eof_out,
   output logic              frame_err
`ifdef GRAY_MINMAX_EN
   ,
   output logic [GRAY_W-1:0] gray_min,
   output logic [GRAY_W-1:0] gray_max
`endif
);

   localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

   fsm_state_e     state_q, state_d;
   logic [X_W-1:0] x_q, x_d, px;
   logic [Y_W-1:0] y_q, y_d, py;
   logic           accept, last_x, last_y;
   side_t          tag_d, side_p0, side_p1;
   logic           vld_p0, vld_p1;

   // Accept/drop decision, coordinate tagging and next counter values
   always_comb begin
      accept  = pix_valid_in && (sof_in || (state_q == ST_ACTIVE));
      px      = sof_in ? '0 : x_q;
      py      = sof_in ? '0 : y_q;
      last_x  = (px == X_LAST);
      last_y  = (py == Y_LAST);
      tag_d.rgb    = rgb_in;
      tag_d.x      = px;
      tag_d.y      = py;
      tag_d.border = (px == '0) || last_x || (py == '0) || last_y;
      tag_d.eof    = last_x && last_y;
      tag_d.err    = sof_in && (state_q == ST_ACTIVE);
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      if (accept) begin
         if (last_x && last_y) begin
            state_d = ST_IDLE;
            x_d     = '0;
            y_d     = '0;
         end else if (last_x) begin
            state_d = ST_ACTIVE;
            x_d     = '0;
            y_d     = py + Y_W'(1);
         end else begin
            state_d = ST_ACTIVE;
            x_d     = px + X_W'(1);
            y_d     = py;
         end
      end
   end

   // Framing FSM state and coordinate counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   // Sideband valid bits for stages p0/p1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p0 <= accept;
         vld_p1 <= vld_p0;
      end
   end

   // Sideband data stages p0/p1, matching the luma datapath depth
   always_ff @(posedge clk) begin
      side_p0 <= tag_d;
      side_p1 <= side_p0;
   end

   // Output stage: data held between pixels, eof/err are single-cycle pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rgb_out    <= '0;
         x_out      <= '0;
         y_out      <= '0;
         border_out <= 1'b0;
         eof_out    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         eof_out   <= vld_p1 && side_p1.eof;
         frame_err <= vld_p1 && side_p1.err;
         if (vld_p1) begin
            rgb_out    <= side_p1.rgb;
            x_out      <= side_p1.x;
            y_out      <= side_p1.y;
            border_out <= side_p1.border;
         end
      end
   end

   gray_luma_pipe #(
      .COEF_R (COEF_R),
      .COEF_G (COEF_G),
      .COEF_B (COEF_B)
   ) u_luma (
      .clk    (clk),
      .rst_n  (rst),
      .vld_i  (accept),
      .rgb_i  (rgb_in),
      .vld_o  (pix_valid_out),
      .gray_o (rgb_gray)
   );

`ifdef GRAY_MINMAX_EN
   logic [GRAY_W-1:0] min_q, max_q, min_nx, max_nx;
   logic              first_px;

   // Fold the visible output pixel into the running trackers; (0,0) restarts them
   always_comb begin
      first_px = (x_out == '0) && (y_out == '0);
      min_nx   = (first_px || (rgb_gray < min_q)) ? rgb_gray : min_q;
      max_nx   = (first_px || (rgb_gray > max_q)) ? rgb_gray : max_q;
   end

   // Running trackers; frame results published only on a completed frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         min_q    <= 8'hFF;
         max_q    <= 8'h00;
         gray_min <= '0;
         gray_max <= '0;
      end else begin
         if (pix_valid_out) begin
            min_q <= min_nx;
            max_q <= max_nx;
         end
         if (eof_out) begin
            gray_min <= min_nx;
            gray_max <= max_nx;
         end
      end
   end
`endif

endmodule

// File: tb/tb_gray_front.sv
// tb_gray_front: table vectors plus scoreboard-checked frames for gray_front.
// A reduced 16x8 frame keeps full-frame runs short; a 1x1 instance covers the single-pixel frame.
module tb_gray_front;
   import gray_front_pkg::*;

   localparam int H = 16;
   localparam int V = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, vin, sof;
   logic [PIX_W-1:0]  rgb;
   logic              pv;
   logic [GRAY_W-1:0] gray;
   logic [PIX_W-1:0]  rgbo;
   logic [X_W-1:0]    xo;
   logic [Y_W-1:0]    yo;
   logic              bo, eo, fe;

   logic              o_vin, o_sof;
   logic [PIX_W-1:0]  o_rgb;
   logic              o_pv;
   logic [GRAY_W-1:0] o_gray;
   logic [PIX_W-1:0]  o_rgbo;
   logic [X_W-1:0]    o_xo;
   logic [Y_W-1:0]    o_yo;
   logic              o_bo, o_eo, o_fe;
`ifdef GRAY_MINMAX_EN
   logic [GRAY_W-1:0] gmin, gmax, o_gmin, o_gmax;
`endif

   gray_front #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .clk(clk), .rst(rst_n), .pix_valid_in(vin), .sof_in(sof), .rgb_in(rgb),
      .pix_valid_out(pv), .rgb_gray(gray), .rgb_out(rgbo), .x_out(xo), .y_out(yo),
      .border_out(bo), .eof_out(eo), .frame_err(fe)
`ifdef GRAY_MINMAX_EN
      , .gray_min(gmin), .gray_max(gmax)
`endif
   );

   gray_front #(.H_ACTIVE(1), .V_ACTIVE(1)) u_one (
      .clk(clk), .rst(rst_n), .pix_valid_in(o_vin), .sof_in(o_sof), .rgb_in(o_rgb),
      .pix_valid_out(o_pv), .rgb_gray(o_gray), .rgb_out(o_rgbo), .x_out(o_xo), .y_out(o_yo),
      .border_out(o_bo), .eof_out(o_eo), .frame_err(o_fe)
`ifdef GRAY_MINMAX_EN
      , .gray_min(o_gmin), .gray_max(o_gmax)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [PIX_W-1:0]  rgb;
      logic [X_W-1:0]    x;
      logic [Y_W-1:0]    y;
      logic              border, eof, err;
      logic [GRAY_W-1:0] gray;
      int                cyc;
   } exp_t;
   exp_t sbq[$];
   exp_t me;

   typedef struct {
      logic              sof;
      logic [PIX_W-1:0]  rgb;
      logic [GRAY_W-1:0] gray;
   } vec_t;
   vec_t tbl[6];

   // reference frame model
   int m_act = 0, mx = 0, my = 0;
   int border_cnt = 0, eof_cnt = 0, err_cnt = 0;
   logic [GRAY_W-1:0] l_gray;
   logic [PIX_W-1:0]  l_rgb;
   logic [X_W-1:0]    l_x;
   logic [Y_W-1:0]    l_y;
   logic              l_b;

   function automatic logic [GRAY_W-1:0] ref_gray(input logic [PIX_W-1:0] c);
      int s;
      s = (int'(c[23:16]) * 77 + int'(c[15:8]) * 150 + int'(c[7:0]) * 29 + 128) >>> 8;
      return (s > 255) ? 8'd255 : 8'(s);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic drive(input logic s, input logic [PIX_W-1:0] c, input logic [GRAY_W-1:0] g);
      exp_t e;
      int ex, ey;
      @(posedge clk); #1;
      vin = 1'b1; sof = s; rgb = c;
      if (s || m_act != 0) begin
         ex = s ? 0 : mx;
         ey = s ? 0 : my;
         e.rgb = c; e.gray = g; e.cyc = cyc;
         e.x = X_W'(ex); e.y = Y_W'(ey);
         e.err = s && (m_act != 0);
         e.eof = (ex == H-1) && (ey == V-1);
         e.border = (ex == 0) || (ex == H-1) || (ey == 0) || (ey == V-1);
         sbq.push_back(e);
         if (e.eof) begin m_act = 0; mx = 0; my = 0; end
         else if (ex == H-1) begin m_act = 1; mx = 0; my = ey + 1; end
         else begin m_act = 1; mx = ex + 1; my = ey; end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         vin = 1'b0; sof = 1'b0; rgb = 24'($urandom);
      end
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge clk);
      chk(name, 64'(sbq.size()), 64'd0);
   endtask

   task automatic clr_cnt();
      border_cnt = 0; eof_cnt = 0; err_cnt = 0;
   endtask

   task automatic rand_pixel(input logic s);
      logic [PIX_W-1:0] c;
      c = 24'($urandom);
      drive(s, c, ref_gray(c));
   endtask

   // output monitor: pops the scoreboard on every output pixel, checks hold otherwise
   always @(negedge clk) begin
      if (rst_n) begin
         n_tests++;
         if (pv) begin
            if (bo) border_cnt++;
            if (eo) eof_cnt++;
            if (fe) err_cnt++;
            if (sbq.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_pixel: got x=%0d y=%0d gray=%0d, expected no output", xo, yo, gray);
            end else begin
               me = sbq.pop_front();
               if (gray !== me.gray || rgbo !== me.rgb || xo !== me.x || yo !== me.y ||
                   bo !== me.border || eo !== me.eof || fe !== me.err || cyc != me.cyc + 3) begin
                  n_fail++;
                  $display("FAIL pixel: got g=%0d rgb=%h x=%0d y=%0d b=%b eof=%b err=%b lat=%0d, expected g=%0d rgb=%h x=%0d y=%0d b=%b eof=%b err=%b lat=3",
                           gray, rgbo, xo, yo, bo, eo, fe, cyc - me.cyc,
                           me.gray, me.rgb, me.x, me.y, me.border, me.eof, me.err);
               end
            end
            l_gray = gray; l_rgb = rgbo; l_x = xo; l_y = yo; l_b = bo;
         end else if (eo || fe || gray !== l_gray || rgbo !== l_rgb || xo !== l_x || yo !== l_y || bo !== l_b) begin
            n_fail++;
            $display("FAIL hold: got g=%0d x=%0d y=%0d eof=%b err=%b, expected g=%0d x=%0d y=%0d eof=0 err=0",
                     gray, xo, yo, eo, fe, l_gray, l_x, l_y);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b1, 24'hFFFFFF, 8'd255};
      tbl[1] = '{1'b0, 24'h000000, 8'd0};
      tbl[2] = '{1'b0, 24'hFF0000, 8'd77};
      tbl[3] = '{1'b0, 24'h00FF00, 8'd149};
      tbl[4] = '{1'b0, 24'h0000FF, 8'd29};
      tbl[5] = '{1'b0, 24'h808080, 8'd128};
      l_gray = '0; l_rgb = '0; l_x = '0; l_y = '0; l_b = 1'b0;

      rst_n = 1'b0; vin = 1'b0; sof = 1'b0; rgb = '0;
      o_vin = 1'b0; o_sof = 1'b0; o_rgb = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(3);
      chk("reset_idle", 64'({pv, gray, rgbo, xo, yo, bo, eo, fe}), 64'd0);
      chk("reset_idle_1x1", 64'({o_pv, o_gray, o_rgbo, o_xo, o_yo, o_bo, o_eo, o_fe}), 64'd0);

      // colour table, then complete the frame with gaps
      clr_cnt();
      for (int i = 0; i < 6; i++) drive(tbl[i].sof, tbl[i].rgb, tbl[i].gray);
      for (int k = 0; k < H*V - 6; k++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         rand_pixel(1'b0);
      end
      idle(1);
      drain("drain_frame1");
      chk("eof_count_frame1", 64'(eof_cnt), 64'd1);

      // pixels without sof after a frame are dropped
      for (int k = 0; k < 3; k++) rand_pixel(1'b0);
      idle(6);
      drain("drain_dropped");

      // full frame with random gaps
      clr_cnt();
      rand_pixel(1'b1);
      for (int k = 1; k < H*V; k++) begin
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         rand_pixel(1'b0);
      end
      for (int k = 0; k < 3; k++) rand_pixel(1'b0);
      idle(1);
      drain("drain_frame2");
      chk("border_count", 64'(border_cnt), 64'(2*H + 2*V - 4));
      chk("eof_count_frame2", 64'(eof_cnt), 64'd1);
      chk("err_count_frame2", 64'(err_cnt), 64'd0);

      // early sof at (10,3), then back-to-back through every x wrap to eof
      clr_cnt();
      rand_pixel(1'b1);
      for (int k = 1; k < 3*H + 10; k++) rand_pixel(1'b0);
      rand_pixel(1'b1);
      for (int k = 1; k < H*V; k++) rand_pixel(1'b0);
      idle(1);
      drain("drain_early_sof");
      chk("err_count_early_sof", 64'(err_cnt), 64'd1);
      chk("eof_count_early_sof", 64'(eof_cnt), 64'd1);

`ifdef GRAY_MINMAX_EN
      // gray-only frame spanning 10..200 in scrambled order
      begin
         int v;
         bit seen;
         for (int k = 0; k < H*V; k++) begin
            v = 10 + (((k * 37) % (H*V)) * 190) / (H*V - 1);
            drive(k == 0, {8'(v), 8'(v), 8'(v)}, 8'(v));
         end
         idle(1);
         seen = 1'b0;
         for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = eo;
         end
         chk("minmax_eof_seen", 64'(seen), 64'd1);
         @(negedge clk);
         chk("minmax_after_eof", 64'({gmin, gmax}), 64'({8'd10, 8'd200}));
         drive(1'b1, 24'h050505, 8'd5);
         drive(1'b0, 24'hFAFAFA, 8'd250);
         drive(1'b0, 24'h070707, 8'd7);
         drive(1'b1, 24'h030303, 8'd3);
         drive(1'b0, 24'hFCFCFC, 8'd252);
         idle(1);
         drain("drain_minmax_abort");
         chk("minmax_abort_unchanged", 64'({gmin, gmax}), 64'({8'd10, 8'd200}));
      end
`endif

      // asynchronous reset in mid-stream
      drive(1'b1, 24'h102030, ref_gray(24'h102030));
      for (int k = 0; k < 4; k++) drive(1'b0, 24'hA0B0C0, ref_gray(24'hA0B0C0));
      #2;
      chk("pre_reset_valid", 64'(pv), 64'd1);
      rst_n = 1'b0;
      sbq.delete();
      m_act = 0; mx = 0; my = 0;
      l_gray = '0; l_rgb = '0; l_x = '0; l_y = '0; l_b = 1'b0;
      #1;
      chk("mid_reset_zero", 64'({pv, gray, rgbo, xo, yo, bo, eo, fe}), 64'd0);
      vin = 1'b0; sof = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      idle(2);
      rand_pixel(1'b0);
      rand_pixel(1'b1);
      rand_pixel(1'b0);
      idle(1);
      drain("drain_after_reset");

      // single-pixel frame: sof and eof on the same pixel, next non-sof pixel dropped
      @(posedge clk); #1 o_vin = 1'b1; o_sof = 1'b1; o_rgb = 24'h808080;
      @(posedge clk); #1 o_sof = 1'b0; o_rgb = 24'h123456;
      @(posedge clk); #1 o_vin = 1'b0;
      @(posedge clk); #1;
      chk("one_px_frame", 64'({o_pv, o_gray, o_rgbo, o_xo, o_yo, o_bo, o_eo, o_fe}),
          64'({1'b1, 8'd128, 24'h808080, 10'd0, 9'd0, 1'b1, 1'b1, 1'b0}));
      @(posedge clk); #1;
      chk("one_px_dropped", 64'({o_pv, o_eo, o_fe}), 64'd0);

      idle(4);
      drain("drain_final");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_front.md
Name: gray_front

Overview:
- Upstream feeder of the cartoon/edge filter.
- Takes the raw camera RGB888 pixel stream with valid and start-of-frame qualifiers, and produces the 8-bit luma that drives the line buffer / Sobel path.
- Also produces a pixel-aligned copy of the RGB, per-pixel x/y coordinates, a 3x3-window border flag, and end-of-frame / framing-error pulses.
- Fixed 3-cycle pipeline, no backpressure.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- COEF_R, 77, red luma weight (Q0.8)
- COEF_G, 150, green luma weight (Q0.8)
- COEF_B, 29, blue luma weight (Q0.8); COEF_R+COEF_G+COEF_B must equal 256

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- pix_valid_in  in  1  rgb_in carries a pixel this cycle
- sof_in  in  1  qualifies the first pixel of a frame; only meaningful with pix_valid_in
- rgb_in  in  24  {R[23:16],G[15:8],B[7:0]}
- pix_valid_out  out  1  outputs below carry an accepted pixel
- rgb_gray  out  8  luma
- rgb_out  out  24  rgb_in delayed to align with rgb_gray
- x_out  out  10  column of the output pixel
- y_out  out  9  row of the output pixel
- border_out  out  1  pixel on row 0, row V_ACTIVE-1, col 0 or col H_ACTIVE-1
- eof_out  out  1  one-cycle pulse, coincident with the last pixel of a frame
- frame_err  out  1  one-cycle pulse, coincident with the first output of a restarted frame

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0.
  - Pipeline valid bits cleared.
  - FSM to IDLE; x/y counters 0.
- Pipeline (advances every clk, no stall; bubbles carry pix_valid=0):
  - S1: register pr=R*COEF_R, pg=G*COEF_G, pb=B*COEF_B (16b each).
  - S2: sum=pr+pg+pb (18b).
  - S3: rgb_gray = min(255, (sum+128)>>8).
- Latency: exactly 3 cycles from pix_valid_in to pix_valid_out.
  - rgb_out, x_out, y_out, border_out, eof_out and frame_err travel through identical 3-deep registers.
  - Data outputs hold their last values when pix_valid_out=0.
- FSM IDLE:
  - pix_valid_in & sof_in: pixel accepted as (0,0); next expected (1,0); go to ACTIVE.
  - pix_valid_in & !sof_in: pixel dropped (never appears at the output, no error pulse).
- FSM ACTIVE, on each pix_valid_in & !sof_in:
  - Accept the pixel at the current (x,y).
  - x==H_ACTIVE-1: x wraps to 0, y increments.
  - Pixel at (H_ACTIVE-1, V_ACTIVE-1): tag eof, return to IDLE.
- FSM ACTIVE, pix_valid_in & sof_in (early SOF):
  - Pixel accepted as (0,0) of a new frame and tagged frame_err.
  - Stay in ACTIVE; no eof for the truncated frame.
- Single-pixel frame (H_ACTIVE=V_ACTIVE=1): first pixel tagged with sof acceptance and eof together, then IDLE.
- Counters never exceed H_ACTIVE-1 / V_ACTIVE-1.

Optional Feature:
- Macro GRAY_MINMAX_EN.
- When defined, adds outputs:
  - gray_min [7:0]: minimum rgb_gray over the completed frame
  - gray_max [7:0]: maximum rgb_gray over the completed frame
- Both update on the cycle after eof_out.
- Running trackers:
  - Reset to min=255, max=0 on each output pixel tagged (0,0).
  - Frames aborted by frame_err do not update the outputs.
  - Reset value of outputs: gray_min=0, gray_max=0.
- When undefined: ports and tracking logic absent; all other behaviour identical.

Decomposition:
- Add to the shared param include:
  - GRAY_DLY=3, so the downstream RGB delay equals SOBEL_DLY plus this stage.
  - Coefficient defaults.
  - Coordinate widths.
- One sub-module, gray_luma_pipe: the 3-stage multiply/sum/round datapath.
- FSM, counters and sideband delay live in the top.

Test Plan:
- Reset release, idle input -> all outputs 0 and pix_valid_out=0; mid-stream rst=0 -> outputs 0 within the same cycle.
- Pixels FFFFFF, 000000, FF0000, 00FF00, 0000FF, 808080 with sof on the first -> rgb_gray 255, 0, 77, 149, 29, 128, each exactly 3 cycles later; rgb_out matches the input.
- Full 640x480 frame with random valid gaps:
  - x/y sequence exact.
  - border_out on 2236 pixels.
  - eof_out once, at (639,479).
  - Pixels without sof afterwards are dropped.
- Early SOF at (100,20) -> frame_err pulse with output (0,0); the following pixel reports (1,0); no eof for the aborted frame.
- Back-to-back valid through the x wrap (639,5)->(0,6) -> no dropped or duplicated coordinates.
- GRAY_MINMAX_EN build: frame of gray values 10..200 -> gray_min=10, gray_max=200 one cycle after eof; aborted frame leaves them unchanged.
